wb_master_bridge: RTL and testbench

//  Wishbone classic initiator for the core/peripheral side of the SoC bus.

---
 rtl/wb_master_bridge_if.sv | 41 ++++
 rtl/wb_master_bridge.sv | 147 ++++++++++++++
 tb/tb_wb_master_bridge.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_master_bridge_if.sv
// rtl/wb_master_bridge_if.sv - request/response and Wishbone signal bundle for wb_master_bridge
// The master modport is the bridge; the slave modport is the core plus responder side.
interface wb_master_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int SEL_WIDTH = DATA_WIDTH / 8;

  logic                  req_valid_i;
  logic                  req_ready_o;
  logic [ADDR_WIDTH-1:0] req_addr_i;
  logic                  req_we_i;
  logic [SEL_WIDTH-1:0]  req_be_i;
  logic [DATA_WIDTH-1:0] req_wdata_i;
  logic                  rsp_valid_o;
  logic [DATA_WIDTH-1:0] rsp_rdata_o;
  logic                  rsp_err_o;
  logic                  wb_cyc_o;
  logic                  wb_stb_o;
  logic                  wb_we_o;
  logic [ADDR_WIDTH-1:0] wb_addr_o;
  logic [SEL_WIDTH-1:0]  wb_sel_o;
  logic [DATA_WIDTH-1:0] wb_wdata_o;
  logic [DATA_WIDTH-1:0] wb_rdata_i;
  logic                  wb_ack_i;
  logic                  wb_err_i;

  modport master (
    input  req_valid_i, req_addr_i, req_we_i, req_be_i, req_wdata_i,
    input  wb_rdata_i, wb_ack_i, wb_err_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_sel_o, wb_wdata_o
  );

  modport slave (
    output req_valid_i, req_addr_i, req_we_i, req_be_i, req_wdata_i,
    output wb_rdata_i, wb_ack_i, wb_err_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_sel_o, wb_wdata_o
  );
endinterface

// File: rtl/wb_master_bridge.sv
// rtl/wb_master_bridge.sv - Wishbone classic initiator: one registered single cycle per request
// Optional BUSY timeout abort is built when WB_MASTER_TIMEOUT_EN is defined.
module wb_master_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   wb_clk_i,
  input  logic                   rst_ni,
  wb_master_bridge_if.master     bus
);
  localparam int SEL_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e                r_state;
  state_e                w_state_nxt;
  logic                  r_req_ready, w_req_ready_nxt;
  logic                  r_rsp_valid, w_rsp_valid_nxt;
  logic [DATA_WIDTH-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
  logic                  r_rsp_err,   w_rsp_err_nxt;
  logic                  r_cyc,       w_cyc_nxt;
  logic                  r_we,        w_we_nxt;
  logic [ADDR_WIDTH-1:0] r_addr,      w_addr_nxt;
  logic [SEL_WIDTH-1:0]  r_sel,       w_sel_nxt;
  logic [DATA_WIDTH-1:0] r_wdata,     w_wdata_nxt;
  logic                  w_timeout;
  logic                  w_accept;
  logic                  w_abort;

`ifdef WB_MASTER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] r_tmo_cnt;

  // Zero on every entry to BUSY because it is held clear outside BUSY.
  always_ff @(posedge wb_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_tmo_cnt <= '0;
    end else if (r_state == S_BUSY) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end else begin
      r_tmo_cnt <= '0;
    end
  end

  assign w_timeout = (r_state == S_BUSY) && (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  logic [31:0] w_unused_tmo;
  assign w_unused_tmo = 32'(TIMEOUT_CYCLES);
  assign w_timeout    = 1'b0;
`endif

  assign w_accept = r_req_ready && bus.req_valid_i;
  // A real ack or err on the same edge as the timeout takes precedence over the abort.
  assign w_abort  = w_timeout && !bus.wb_ack_i && !bus.wb_err_i;

  always_ff @(posedge wb_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_req_ready_nxt = 1'b0;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_rsp_err_nxt   = r_rsp_err;
    w_cyc_nxt       = r_cyc;
    w_we_nxt        = r_we;
    w_addr_nxt      = r_addr;
    w_sel_nxt       = r_sel;
    w_wdata_nxt     = r_wdata;
    case (r_state)
      S_IDLE: begin
        w_req_ready_nxt = 1'b1;
        if (w_accept) begin
          w_state_nxt     = S_BUSY;
          w_req_ready_nxt = 1'b0;
          w_cyc_nxt       = 1'b1;
          w_we_nxt        = bus.req_we_i;
          w_addr_nxt      = bus.req_addr_i;
          w_sel_nxt       = bus.req_be_i;
          w_wdata_nxt     = bus.req_wdata_i;
        end
      end
      S_BUSY: begin
        if (bus.wb_ack_i || bus.wb_err_i || w_abort) begin
          w_state_nxt     = S_RESP;
          w_cyc_nxt       = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = bus.wb_err_i || w_abort;
          w_rsp_rdata_nxt = (bus.wb_ack_i && !bus.wb_err_i && !r_we) ? bus.wb_rdata_i : '0;
        end
      end
      S_RESP: begin
        w_state_nxt     = S_IDLE;
        w_req_ready_nxt = 1'b1;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cyc_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_cyc       <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_sel       <= '0;
      r_wdata     <= '0;
    end else begin
      r_req_ready <= w_req_ready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_cyc       <= w_cyc_nxt;
      r_we        <= w_we_nxt;
      r_addr      <= w_addr_nxt;
      r_sel       <= w_sel_nxt;
      r_wdata     <= w_wdata_nxt;
    end
  end

  assign bus.req_ready_o = r_req_ready;
  assign bus.rsp_valid_o = r_rsp_valid;
  assign bus.rsp_rdata_o = r_rsp_rdata;
  assign bus.rsp_err_o   = r_rsp_err;
  assign bus.wb_cyc_o    = r_cyc;
  assign bus.wb_stb_o    = r_cyc;
  assign bus.wb_we_o     = r_we;
  assign bus.wb_addr_o   = r_addr;
  assign bus.wb_sel_o    = r_sel;
  assign bus.wb_wdata_o  = r_wdata;
endmodule

// File: tb/tb_wb_master_bridge.sv
// tb/tb_wb_master_bridge.sv - directed vector bench for wb_master_bridge
// Timeout expectations follow WB_MASTER_TIMEOUT_EN with TIMEOUT_CYCLES=8.
module tb_wb_master_bridge;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  wb_master_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  wb_master_bridge #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .wb_clk_i(clk),
    .rst_ni(rst_n),
    .bus(bus)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          delay;
    logic        ack;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_txn(input int idx, input vec_t v);
    int guard;
    int cyc_hi;
    @(negedge clk);
    guard = 0;
    while (!bus.req_ready_o && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check($sformatf("v%0d_ready", idx), bus.req_ready_o, 1);
    bus.req_addr_i  = v.addr;
    bus.req_we_i    = v.we;
    bus.req_be_i    = v.be;
    bus.req_wdata_i = v.wdata;
    bus.req_valid_i = 1'b1;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    bus.req_wdata_i = 32'h0BAD_0BAD;
    check($sformatf("v%0d_cyc", idx), {bus.wb_cyc_o, bus.wb_stb_o, bus.req_ready_o}, 3'b110);
    check($sformatf("v%0d_we", idx), bus.wb_we_o, v.we);
    check($sformatf("v%0d_addr", idx), bus.wb_addr_o, v.addr);
    check($sformatf("v%0d_sel", idx), bus.wb_sel_o, v.be);
    cyc_hi = 1;
    for (int i = 0; i < v.delay; i++) begin
      @(negedge clk);
      if (bus.wb_cyc_o) cyc_hi++;
    end
    check($sformatf("v%0d_wdata_stable", idx), bus.wb_wdata_o, v.wdata);
    check($sformatf("v%0d_addr_stable", idx), bus.wb_addr_o, v.addr);
    bus.wb_ack_i   = v.ack;
    bus.wb_err_i   = v.err;
    bus.wb_rdata_i = v.rdata;
    @(negedge clk);
    bus.wb_ack_i   = 1'b0;
    bus.wb_err_i   = 1'b0;
    bus.wb_rdata_i = 32'h5A5A_5A5A;
    check($sformatf("v%0d_rsp", idx), {bus.wb_cyc_o, bus.rsp_valid_o}, 2'b01);
    check($sformatf("v%0d_rdata", idx), bus.rsp_rdata_o, v.exp_rdata);
    check($sformatf("v%0d_err", idx), bus.rsp_err_o, v.exp_err);
    check($sformatf("v%0d_cyc_len", idx), cyc_hi, v.delay + 1);
    @(negedge clk);
    check($sformatf("v%0d_pulse_end", idx), {bus.rsp_valid_o, bus.req_ready_o}, 2'b01);
    check($sformatf("v%0d_rdata_hold", idx), bus.rsp_rdata_o, v.exp_rdata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] b2b_addr[3];
    logic [31:0] b2b_data[3];
    int          cnt, low, k, starts, idx, hi;
    logic        prev_ready, seen;

    vecs[0] = '{1'b0, 32'h0010_0004, 4'hF, 32'h0000_0000, 1, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
    vecs[1] = '{1'b1, 32'h0000_0008, 4'hF, 32'h1234_5678, 0, 1'b1, 1'b0, 32'hAAAA_5555, 32'h0000_0000, 1'b0};
    vecs[2] = '{1'b0, 32'h0000_0010, 4'h3, 32'h0000_0000, 0, 1'b1, 1'b1, 32'h0000_0011, 32'h0000_0000, 1'b1};
    vecs[3] = '{1'b0, 32'h8000_00FC, 4'hC, 32'h0000_0000, 3, 1'b1, 1'b0, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0};
    vecs[4] = '{1'b1, 32'h0000_0020, 4'h1, 32'hFFFF_FFFF, 2, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[5] = '{1'b0, 32'h0000_0024, 4'hF, 32'h0000_0000, 1, 1'b0, 1'b1, 32'h7777_7777, 32'h0000_0000, 1'b1};

    bus.req_valid_i = 1'b0;
    bus.req_addr_i  = '0;
    bus.req_we_i    = 1'b0;
    bus.req_be_i    = '0;
    bus.req_wdata_i = '0;
    bus.wb_rdata_i  = '0;
    bus.wb_ack_i    = 1'b0;
    bus.wb_err_i    = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_outputs", {bus.req_ready_o, bus.rsp_valid_o, bus.rsp_err_o, bus.wb_cyc_o,
                            bus.wb_stb_o, bus.wb_we_o}, 6'b0);
    check("reset_buses", {bus.rsp_rdata_o, bus.wb_addr_o}, 64'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", bus.req_ready_o, 1);

    for (int i = 0; i < 6; i++) run_txn(i, vecs[i]);

    // Spurious ack/err while idle
    bus.wb_ack_i = 1'b1;
    bus.wb_err_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("spurious_%0d", i), {bus.rsp_valid_o, bus.wb_cyc_o}, 2'b00);
    end
    bus.wb_ack_i = 1'b0;
    bus.wb_err_i = 1'b0;

    // Back-to-back reads with req_valid_i held
    b2b_addr[0] = 32'h0000_0100; b2b_data[0] = 32'hA000_0001;
    b2b_addr[1] = 32'h0000_0104; b2b_data[1] = 32'hB000_0002;
    b2b_addr[2] = 32'h0000_0108; b2b_data[2] = 32'hC000_0003;
    @(negedge clk);
    idx = 0;
    bus.req_we_i    = 1'b0;
    bus.req_be_i    = 4'hF;
    bus.req_addr_i  = b2b_addr[0];
    bus.req_valid_i = 1'b1;
    prev_ready = bus.req_ready_o;
    cnt = 0; low = 0; k = 0; starts = 0; seen = 1'b0;
    for (int c = 0; c < 60 && k < 3; c++) begin
      @(negedge clk);
      if (bus.rsp_valid_o) begin
        check($sformatf("b2b_rdata_%0d", k), bus.rsp_rdata_o, b2b_data[k]);
        k++;
      end
      if (bus.wb_cyc_o) begin
        if (cnt == 0) begin
          if (seen) check($sformatf("b2b_gap_%0d", starts), low >= 1, 1);
          if (starts < 3) check($sformatf("b2b_addr_%0d", starts), bus.wb_addr_o, b2b_addr[starts]);
          starts++;
          seen = 1'b1;
        end
        cnt++;
        low = 0;
      end else begin
        cnt = 0;
        low++;
      end
      bus.wb_ack_i   = bus.wb_cyc_o && (cnt == 2);
      bus.wb_rdata_i = (bus.wb_ack_i && starts > 0) ? b2b_data[starts-1] : 32'h0;
      if (prev_ready && bus.req_valid_i) begin
        idx++;
        if (idx < 3) bus.req_addr_i = b2b_addr[idx];
        else bus.req_valid_i = 1'b0;
      end
      prev_ready = bus.req_ready_o;
    end
    bus.req_valid_i = 1'b0;
    bus.wb_ack_i    = 1'b0;
    check("b2b_responses", k, 3);

    // Unacknowledged read: timeout abort or indefinite wait
    repeat (2) @(negedge clk);
    bus.req_addr_i  = 32'h0000_0200;
    bus.req_valid_i = 1'b1;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    hi = 0;
`ifdef WB_MASTER_TIMEOUT_EN
    for (int c = 0; c < 50 && bus.wb_cyc_o; c++) begin
      hi++;
      @(negedge clk);
    end
    check("tmo_cyc_len", hi, 8);
    check("tmo_rsp", {bus.wb_cyc_o, bus.rsp_valid_o, bus.rsp_err_o}, 3'b011);
    check("tmo_rdata", bus.rsp_rdata_o, 32'h0);
`else
    for (int c = 0; c < 1000; c++) begin
      if (bus.wb_cyc_o && !bus.rsp_valid_o) hi++;
      @(negedge clk);
    end
    check("notmo_cyc_len", hi, 1000);
    bus.wb_ack_i   = 1'b1;
    bus.wb_rdata_i = 32'h0F0F_0F0F;
    @(negedge clk);
    bus.wb_ack_i = 1'b0;
    check("notmo_rsp", {bus.rsp_valid_o, bus.rsp_err_o}, 2'b10);
    check("notmo_rdata", bus.rsp_rdata_o, 32'h0F0F_0F0F);
`endif

    // Async reset while BUSY
    repeat (2) @(negedge clk);
    bus.req_addr_i  = 32'h0000_0300;
    bus.req_valid_i = 1'b1;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    check("rst_busy_pre", bus.wb_cyc_o, 1);
    #2;
    rst_n = 1'b0;
    bus.wb_ack_i = 1'b1;
    #1;
    check("rst_async_outputs", {bus.wb_cyc_o, bus.wb_stb_o, bus.req_ready_o, bus.rsp_valid_o,
                                bus.rsp_err_o, bus.wb_we_o}, 6'b0);
    check("rst_async_buses", {bus.rsp_rdata_o, bus.wb_addr_o}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_release_ready", {bus.req_ready_o, bus.rsp_valid_o, bus.wb_cyc_o}, 3'b100);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("rst_no_stale_%0d", i), bus.rsp_valid_o, 0);
    end
    bus.wb_ack_i = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
